sobel_gradient: RTL and testbench



---
 rtl/sobel_pkg.sv | 11 +
 rtl/sobel_gradient_if.sv | 20 ++
 rtl/sobel_line_buffer.sv | 15 +
 rtl/sobel_gradient.sv | 121 ++++++++++++
 tb/tb_sobel_gradient.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared pixel/gradient types, FSM states and the weighted 3-tap Sobel sum
package sobel_pkg;
  localparam int PIX_W = 8;
  localparam int GRAD_W = 16;
  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef enum logic {FILL, RUN} sobel_state_t;
  function automatic logic signed [10:0] tap_sum(pixel_t a, pixel_t b, pixel_t c);
    return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
  endfunction
endpackage

// File: rtl/sobel_gradient_if.sv
// sobel_gradient_if: pixel stream in (pix_in/pix_valid/sof), gradients out (vert_out/horz_out/out_valid/out_last, out_col/out_row with SOBEL_COORD_EN); slave=DUT, master=source/sink
interface sobel_gradient_if;
  import sobel_pkg::*;
  pixel_t pix_in;
  logic pix_valid;
  logic sof;
  grad_t vert_out;
  grad_t horz_out;
  logic out_valid;
  logic out_last;
`ifdef SOBEL_COORD_EN
  logic [15:0] out_col;
  logic [15:0] out_row;
  modport slave(input pix_in, pix_valid, sof, output vert_out, horz_out, out_valid, out_last, out_col, out_row);
  modport master(output pix_in, pix_valid, sof, input vert_out, horz_out, out_valid, out_last, out_col, out_row);
`else
  modport slave(input pix_in, pix_valid, sof, output vert_out, horz_out, out_valid, out_last);
  modport master(output pix_in, pix_valid, sof, input vert_out, horz_out, out_valid, out_last);
`endif
endinterface

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one row of pixels (ports clk, we, addr, wr_data, rd_data), combinational read returns the old word while the same address is written on the edge
module sobel_line_buffer import sobel_pkg::*; #(
  parameter int DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  pixel_t                   wr_data,
  output pixel_t                   rd_data
);
  pixel_t mem [DEPTH];
  assign rd_data = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wr_data;
endmodule

// File: rtl/sobel_gradient.sv
// sobel_gradient: streaming 3x3 Sobel Gx/Gy (ports clk, reset, bus: sobel_gradient_if.slave), 2-edge latency, SOBEL_COORD_EN adds out_col/out_row
module sobel_gradient import sobel_pkg::*; #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic             clk,
  input logic             reset,
  sobel_gradient_if.slave bus
);
  localparam int AW = $clog2(IMG_W);
  localparam logic [15:0] W_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] H_LAST = 16'(IMG_H - 1);
  sobel_state_t state_q, state_d;
  logic [15:0] col_q, col_d, row_q, row_d, pix_col, pix_row;
  logic accept;
  pixel_t lb0_rd, lb1_rd;
  pixel_t [2:0] s1_col_q, s1_col_d;
  logic s1_valid_q, s1_valid_d, s1_emit_q, s1_emit_d, s1_last_q, s1_last_d;
  pixel_t [2:0][2:0] win_q, win_d;
  logic s2_emit_q, s2_emit_d, s2_last_q, s2_last_d;
  logic signed [10:0] gx, gy;
  grad_t vert_q, vert_d, horz_q, horz_d;
  logic valid_q, valid_d, last_q, last_d;
`ifdef SOBEL_COORD_EN
  logic [15:0] s1_ccol_q, s1_ccol_d, s1_crow_q, s1_crow_d;
  logic [15:0] s2_ccol_q, s2_ccol_d, s2_crow_q, s2_crow_d;
  logic [15:0] ocol_q, ocol_d, orow_q, orow_d;
`endif
  sobel_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .we(accept), .addr(pix_col[AW-1:0]), .wr_data(lb1_rd), .rd_data(lb0_rd)
  );
  sobel_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .we(accept), .addr(pix_col[AW-1:0]), .wr_data(bus.pix_in), .rd_data(lb1_rd)
  );
  always_comb begin
    accept = bus.pix_valid;
    pix_col = bus.sof ? '0 : col_q;
    pix_row = bus.sof ? '0 : row_q;
    col_d = !accept ? col_q : pix_col == W_LAST ? '0 : pix_col + 16'd1;
    row_d = !accept ? row_q : pix_col != W_LAST ? pix_row : pix_row == H_LAST ? '0 : pix_row + 16'd1;
    state_d = !accept ? state_q : row_d >= 16'd2 ? RUN : FILL;
    s1_valid_d = accept;
    s1_col_d = accept ? {bus.pix_in, lb1_rd, lb0_rd} : s1_col_q;
    s1_emit_d = accept && !bus.sof && state_q == RUN && col_q >= 16'd2;
    s1_last_d = pix_row == H_LAST && pix_col == W_LAST;
    for (int r = 0; r < 3; r++)
      win_d[r] = s1_valid_q ? {s1_col_q[r], win_q[r][2:1]} : win_q[r];
    s2_emit_d = s1_valid_q && s1_emit_q;
    s2_last_d = s1_valid_q && s1_emit_q && s1_last_q;
    gx = tap_sum(win_q[0][2], win_q[1][2], win_q[2][2]) - tap_sum(win_q[0][0], win_q[1][0], win_q[2][0]);
    gy = tap_sum(win_q[2][0], win_q[2][1], win_q[2][2]) - tap_sum(win_q[0][0], win_q[0][1], win_q[0][2]);
    vert_d = s2_emit_q ? {{5{gy[10]}}, gy} : vert_q;
    horz_d = s2_emit_q ? {{5{gx[10]}}, gx} : horz_q;
    valid_d = s2_emit_q;
    last_d = s2_emit_q && s2_last_q;
`ifdef SOBEL_COORD_EN
    s1_ccol_d = accept ? pix_col - 16'd1 : s1_ccol_q;
    s1_crow_d = accept ? pix_row - 16'd1 : s1_crow_q;
    s2_ccol_d = s1_valid_q ? s1_ccol_q : s2_ccol_q;
    s2_crow_d = s1_valid_q ? s1_crow_q : s2_crow_q;
    ocol_d = s2_emit_q ? s2_ccol_q : ocol_q;
    orow_d = s2_emit_q ? s2_crow_q : orow_q;
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= FILL;
      col_q <= '0;
      row_q <= '0;
      s1_valid_q <= 1'b0;
      s1_col_q <= '0;
      s1_emit_q <= 1'b0;
      s1_last_q <= 1'b0;
      win_q <= '0;
      s2_emit_q <= 1'b0;
      s2_last_q <= 1'b0;
      vert_q <= '0;
      horz_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
`ifdef SOBEL_COORD_EN
      s1_ccol_q <= '0;
      s1_crow_q <= '0;
      s2_ccol_q <= '0;
      s2_crow_q <= '0;
      ocol_q <= '0;
      orow_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      s1_valid_q <= s1_valid_d;
      s1_col_q <= s1_col_d;
      s1_emit_q <= s1_emit_d;
      s1_last_q <= s1_last_d;
      win_q <= win_d;
      s2_emit_q <= s2_emit_d;
      s2_last_q <= s2_last_d;
      vert_q <= vert_d;
      horz_q <= horz_d;
      valid_q <= valid_d;
      last_q <= last_d;
`ifdef SOBEL_COORD_EN
      s1_ccol_q <= s1_ccol_d;
      s1_crow_q <= s1_crow_d;
      s2_ccol_q <= s2_ccol_d;
      s2_crow_q <= s2_crow_d;
      ocol_q <= ocol_d;
      orow_q <= orow_d;
`endif
    end
  assign bus.vert_out = vert_q;
  assign bus.horz_out = horz_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last = last_q;
`ifdef SOBEL_COORD_EN
  assign bus.out_col = ocol_q;
  assign bus.out_row = orow_q;
`endif
endmodule

// File: tb/tb_sobel_gradient.sv
// tb_sobel_gradient: directed and gapped-random frames checked against a kernel-convolution model of the image
module tb_sobel_gradient;
  import sobel_pkg::*;
  localparam int W = 8;
  localparam int H = 6;
  typedef struct {int cyc; int gx; int gy; bit last; int r; int c;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sobel_gradient_if bus();
  sobel_gradient #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .reset(reset), .bus(bus));
  int KX[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int KY[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
  int img[H][W];
  exp_t q[$];
  exp_t e;
  int got_h[$];
  int got_v[$];
  int mx = 0, my = 0, cyc = 0, tests = 0, fails = 0;
  int n_out = 0, n_last = 0, last_idx = 0;
  int first_r = -1, first_c = -1, last_r = -1, last_c = -1;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endfunction
  task automatic model_accept(input int p, input bit s);
    int gx = 0;
    int gy = 0;
    exp_t m;
    if (s) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = p;
    if (my >= 2 && mx >= 2) begin
      for (int dy = 0; dy < 3; dy++)
        for (int dx = 0; dx < 3; dx++) begin
          gx += KX[dy][dx] * img[my-2+dy][mx-2+dx];
          gy += KY[dy][dx] * img[my-2+dy][mx-2+dx];
        end
      m = '{cyc + 2, gx, gy, (my == H-1 && mx == W-1), my - 1, mx - 1};
      q.push_back(m);
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my++;
      if (my == H) my = 0;
    end
  endtask
  task automatic step(input bit v, input int p, input bit s);
    bus.pix_valid = v;
    bus.pix_in = 8'(p);
    bus.sof = s;
    @(posedge clk);
    #1;
    if (v) model_accept(p, s);
    bus.pix_valid = 1'b0;
    bus.sof = 1'b0;
  endtask
  function automatic int pix_of(input int kind, input int y, input int x);
    case (kind)
      0: return 100;
      1: return x >= 4 ? 255 : 0;
      2: return y >= 3 ? 255 : 0;
      3: return y >= 3 ? 0 : 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction
  task automatic send(input int kind, input bit gaps, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 0, 1'b0);
      step(1'b1, pix_of(kind, i / W, i % W), i == 0);
    end
  endtask
  task automatic drain();
    repeat (5) step(1'b0, 0, 1'b0);
    chk("queue_empty", q.size(), 0);
  endtask
  task automatic clear_stats();
    n_out = 0;
    n_last = 0;
    last_idx = 0;
    got_h.delete();
    got_v.delete();
  endtask
  always @(negedge clk)
    if (cyc > 0) begin
      if (bus.out_valid === 1'b1) begin
        n_out++;
        got_h.push_back(int'({16'b0, bus.horz_out}));
        got_v.push_back(int'({16'b0, bus.vert_out}));
        if (bus.out_last) begin
          n_last++;
          last_idx = n_out;
        end
`ifdef SOBEL_COORD_EN
        if (n_out == 1) begin
          first_r = int'(bus.out_row);
          first_c = int'(bus.out_col);
        end
        if (bus.out_last) begin
          last_r = int'(bus.out_row);
          last_c = int'(bus.out_col);
        end
`endif
        if (q.size() == 0) chk("out_valid_unexpected", int'(bus.out_valid), 0);
        else begin
          e = q.pop_front();
          chk("latency_edge", cyc, e.cyc);
          chk("vert_out", int'(bus.vert_out), e.gy);
          chk("horz_out", int'(bus.horz_out), e.gx);
          chk("out_last", int'(bus.out_last), int'(e.last));
`ifdef SOBEL_COORD_EN
          chk("out_row", int'(bus.out_row), e.r);
          chk("out_col", int'(bus.out_col), e.c);
`endif
        end
      end else begin
        chk("out_last_without_valid", int'(bus.out_last === 1'b1), 0);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          chk("out_valid_missing", int'(bus.out_valid === 1'b1), 1);
          void'(q.pop_front());
        end
      end
    end
  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_in = '0;
    bus.sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_last", int'(bus.out_last), 0);
    chk("reset_vert_out", int'(bus.vert_out), 0);
    chk("reset_horz_out", int'(bus.horz_out), 0);
    clear_stats();
    send(0, 1'b0, W * H);
    drain();
    chk("uniform_count", n_out, 24);
    chk("uniform_last_count", n_last, 1);
    chk("uniform_last_index", last_idx, 24);
    for (int i = 0; i < got_h.size(); i++) begin
      chk("uniform_horz", got_h[i], 0);
      chk("uniform_vert", got_v[i], 0);
    end
    clear_stats();
    send(1, 1'b0, W * H);
    drain();
    chk("vstep_count", n_out, 24);
    for (int i = 0; i < got_h.size(); i++) begin
      chk("vstep_horz", got_h[i], (i % 6 + 1 == 3 || i % 6 + 1 == 4) ? 1020 : 0);
      chk("vstep_vert", got_v[i], 0);
    end
    clear_stats();
    send(2, 1'b0, W * H);
    drain();
    chk("hstep_count", n_out, 24);
    for (int i = 0; i < got_v.size(); i++) begin
      chk("hstep_vert", got_v[i], (i / 6 + 1 == 2 || i / 6 + 1 == 3) ? 1020 : 0);
      chk("hstep_horz", got_h[i], 0);
    end
    clear_stats();
    send(3, 1'b0, W * H);
    drain();
    chk("neg_hstep_count", n_out, 24);
    for (int i = 0; i < got_v.size(); i++)
      chk("neg_hstep_vert_raw", got_v[i], (i / 6 + 1 == 2 || i / 6 + 1 == 3) ? 'hFC04 : 0);
    clear_stats();
    send(4, 1'b1, W * H);
    drain();
    chk("gapped_random_count", n_out, 24);
    chk("gapped_random_last", n_last, 1);
    clear_stats();
    send(4, 1'b0, 20);
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mx = 0;
    my = 0;
    chk("reset_midframe_valid", int'(bus.out_valid), 0);
    repeat (3) step(1'b0, 0, 1'b0);
    chk("reset_midframe_quiet", n_out, 0);
    send(4, 1'b0, W * H);
    drain();
    chk("after_reset_count", n_out, 24);
    chk("after_reset_last", n_last, 1);
    clear_stats();
    send(4, 1'b0, 21);
    send(4, 1'b1, W * H);
    drain();
    chk("sof_midrow_count", n_out, 27);
    chk("sof_midrow_last", n_last, 1);
    clear_stats();
    first_r = -1;
    first_c = -1;
    send(4, 1'b0, W * H);
    send(4, 1'b0, W * H);
    drain();
    chk("b2b_count", n_out, 48);
    chk("b2b_last_count", n_last, 2);
`ifdef SOBEL_COORD_EN
    chk("b2b_first_row", first_r, 1);
    chk("b2b_first_col", first_c, 1);
    chk("b2b_last_row", last_r, 4);
    chk("b2b_last_col", last_c, 6);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
